// File: rtl/bcd_updown_counter_n.sv
// N-digit synchronous BCD up/down counter with validated parallel load,
// optional saturation at the range ends, look-ahead terminal count and
// registered wrap / load-error pulses.
module bcd_updown_counter_n #(
   parameter int DIGITS   = 4,
   parameter bit SATURATE = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  mode,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   din,
   output logic [4*DIGITS-1:0]   q,
   output logic                  tc,
   output logic                  wrap_o,
   output logic                  load_err
);

   localparam int W = 4 * DIGITS;

   logic [W-1:0] q_q, q_d;
   logic         wrap_q, wrap_d;
   logic         err_q, err_d;
   logic         all9, all0, din_ok, at_end;
   logic         carry;
   logic [3:0]   dig;

   // Range-end detection on the current count and BCD validation of din
   always_comb begin
      all9   = 1'b1;
      all0   = 1'b1;
      din_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (q_q[4*i +: 4] != 4'd9) all9 = 1'b0;
         if (q_q[4*i +: 4] != 4'd0) all0 = 1'b0;
         if (din[4*i +: 4] > 4'd9)  din_ok = 1'b0;
      end
      at_end = mode ? all0 : all9;
   end

   // Next count: load has priority over counting; digits ripple on the
   // look-ahead condition "all lower digits at 9 (up) / at 0 (down)"
   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      err_d  = 1'b0;
      carry  = 1'b1;
      dig    = 4'd0;
      if (load) begin
         if (din_ok) q_d   = din;
         else        err_d = 1'b1;
      end else if (en) begin
         if (!(SATURATE && at_end)) begin
            wrap_d = at_end;
            for (int i = 0; i < DIGITS; i++) begin
               dig = q_q[4*i +: 4];
               if (carry) begin
                  if (mode) begin
                     q_d[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
                     carry         = (dig == 4'd0);
                  end else begin
                     q_d[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
                     carry         = (dig == 4'd9);
                  end
               end
            end
         end
      end
   end

   // State registers with synchronous active-high reset taking priority
   always_ff @(posedge clk) begin
      if (reset) begin
         q_q    <= '0;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
         err_q  <= err_d;
      end
   end

   assign q        = q_q;
   assign wrap_o   = wrap_q;
   assign load_err = err_q;
   assign tc       = en & ~load & at_end;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Bench for bcd_updown_counter_n: a wrapping and a saturating instance share
// the same stimulus and are compared against an integer-valued model.
module tb_bcd_updown_counter_n;

   localparam int MAXV = 9999;

   logic        clk = 1'b0;
   logic        reset, en, mode, load;
   logic [15:0] din;
   logic [15:0] q0, q1;
   logic        tc0, tc1, wr0, wr1, er0, er1;

   int checks = 0;
   int errors = 0;
   bit init_done = 1'b0;

   int mval [2];
   bit mwrap[2];
   bit merr [2];

   always #5 clk = ~clk;

   bcd_updown_counter_n #(.DIGITS(4), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .din(din),
      .q(q0), .tc(tc0), .wrap_o(wr0), .load_err(er0));

   bcd_updown_counter_n #(.DIGITS(4), .SATURATE(1'b1)) u_sat (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .din(din),
      .q(q1), .tc(tc1), .wrap_o(wr1), .load_err(er1));

   function automatic int bcd2int(input logic [15:0] b);
      int r = 0;
      for (int i = 3; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [15:0] int2bcd(input int v);
      logic [15:0] b = '0;
      int t = v;
      for (int i = 0; i < 4; i++) begin
         b[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return b;
   endfunction

   function automatic bit bcd_ok(input logic [15:0] b);
      bit ok = 1'b1;
      for (int i = 0; i < 4; i++) if (b[4*i +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock step: drive inputs, check tc before the edge, advance the
   // model, then check registered outputs just after the edge.
   task automatic step(input bit r, input bit e, input bit m, input bit l, input logic [15:0] d);
      bit at_end;
      reset = r; en = e; mode = m; load = l; din = d;
      #2;
      if (init_done) begin
         for (int k = 0; k < 2; k++) begin
            at_end = m ? (mval[k] == 0) : (mval[k] == MAXV);
            chk(k == 0 ? "tc_wrap" : "tc_sat", 16'(k == 0 ? tc0 : tc1), 16'(e & ~l & at_end));
         end
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (r) begin
            mval[k] = 0; mwrap[k] = 0; merr[k] = 0;
         end else if (l) begin
            mwrap[k] = 0;
            merr[k]  = !bcd_ok(d);
            if (bcd_ok(d)) mval[k] = bcd2int(d);
         end else if (e) begin
            merr[k] = 0;
            if (!m && mval[k] == MAXV) begin
               mwrap[k] = (k == 0);
               if (k == 0) mval[k] = 0;
            end else if (m && mval[k] == 0) begin
               mwrap[k] = (k == 0);
               if (k == 0) mval[k] = MAXV;
            end else begin
               mwrap[k] = 0;
               mval[k]  = m ? mval[k] - 1 : mval[k] + 1;
            end
         end else begin
            mwrap[k] = 0; merr[k] = 0;
         end
      end
      init_done = 1'b1;
      #1;
      chk("q_wrap",    q0,        int2bcd(mval[0]));
      chk("q_sat",     q1,        int2bcd(mval[1]));
      chk("wrap_wrap", 16'(wr0),  16'(mwrap[0]));
      chk("wrap_sat",  16'(wr1),  16'(mwrap[1]));
      chk("err_wrap",  16'(er0),  16'(merr[0]));
      chk("err_sat",   16'(er1),  16'(merr[1]));
   endtask

   initial begin
      logic [15:0] rd;
      reset = 1'b1; en = 1'b1; mode = 1'b0; load = 1'b1; din = 16'h1234;
      #1;
      // reset with en/load active
      step(1, 1, 0, 1, 16'h1234);
      step(1, 1, 0, 1, 16'h1234);
      // load 0998, count up through 0999, 1000, 1001
      step(0, 0, 0, 1, 16'h0998);
      step(0, 1, 0, 0, 16'h0000);
      step(0, 1, 0, 0, 16'h0000);
      step(0, 1, 0, 0, 16'h0000);
      // up wrap from 9999
      step(0, 0, 0, 1, 16'h9999);
      step(0, 1, 0, 0, 16'h0000);
      step(0, 0, 0, 0, 16'h0000);
      // down from 1000, then down wrap from 0000
      step(0, 0, 1, 1, 16'h1000);
      step(0, 1, 1, 0, 16'h0000);
      step(0, 1, 1, 0, 16'h0000);
      step(0, 0, 1, 1, 16'h0000);
      step(0, 1, 1, 0, 16'h0000);
      step(0, 0, 1, 0, 16'h0000);
      // rejected load, then idle hold
      step(0, 0, 0, 1, 16'h0123);
      step(0, 1, 0, 1, 16'h01A3);
      step(0, 0, 0, 0, 16'h0000);
      step(0, 0, 1, 0, 16'h0000);
      // saturation at all-9s, then reverse direction
      step(0, 0, 0, 1, 16'h9999);
      step(0, 1, 0, 0, 16'h0000);
      step(0, 1, 0, 0, 16'h0000);
      step(0, 1, 0, 0, 16'h0000);
      step(0, 1, 1, 0, 16'h0000);
      // back-to-back wraps by toggling mode at the ends
      step(0, 0, 0, 1, 16'h9999);
      step(0, 1, 0, 0, 16'h0000);
      step(0, 1, 1, 0, 16'h0000);
      step(0, 1, 0, 0, 16'h0000);
      // reset coincident with a wrap
      step(0, 0, 0, 1, 16'h9999);
      step(1, 1, 0, 0, 16'h0000);
      // randomized phase
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 9))
            0:       rd = 16'h9999;
            1:       rd = 16'h0000;
            2:       rd = 16'($urandom);
            default: rd = int2bcd(int'($urandom_range(0, MAXV)));
         endcase
         step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
              1'($urandom), $urandom_range(0, 7) == 0, rd);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
